fsm_job_sequencer: RTL and testbench

Initiator side of the single-cycle `start` / `done` worker handshake used by the FPGA control FSMs. On one `go` command it issues a programmed number of jobs back-to-back to one worker FSM. For each job it pulses `worker_start`, waits for `worker_done`, and can insert dead cycles between jobs. It counts completed jobs, reports batch completion, and aborts with a sticky error if the worker stops responding.

---
 rtl/fsm_job_sequencer.sv | 143 ++++++++++++++
 tb/tb_fsm_job_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_job_sequencer.sv
// fsm_job_sequencer: initiator side of the single-cycle start/done worker
// handshake. On one go command it issues a batch of jobs to a worker FSM,
// optionally spacing them with dead cycles. It counts completed jobs, pulses
// complete at the end of the batch, and aborts with a sticky timeout error
// when the worker stops answering.
module fsm_job_sequencer #(
    parameter int JOB_W   = 8,
    parameter int GAP_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [JOB_W-1:0] num_jobs,
    input  logic [GAP_W-1:0] gap,
    output logic             worker_start,
    input  logic             worker_done,
    output logic             busy,
    output logic             complete,
    output logic             timeout_err,
    output logic [JOB_W-1:0] jobs_done
);

    // The timer only needs to hold 0 .. TIMEOUT-1 WAIT_DONE cycles.
    localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_GAP,
        S_FINISH
    } state_e;

    state_e             state_q, state_d;
    logic [JOB_W-1:0]   num_q, num_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [JOB_W-1:0]   jobs_done_q, jobs_done_d;
    logic               timeout_err_q, timeout_err_d;
    logic [JOB_W-1:0]   jobs_inc;

    assign jobs_inc = jobs_done_q + JOB_W'(1);

    // State and datapath registers; reset is asynchronous so the strobes
    // decoded from state_q drop immediately when reset rises.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            num_q         <= '0;
            gap_q         <= '0;
            gap_cnt_q     <= '0;
            timer_q       <= '0;
            jobs_done_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            num_q         <= num_d;
            gap_q         <= gap_d;
            gap_cnt_q     <= gap_cnt_d;
            timer_q       <= timer_d;
            jobs_done_q   <= jobs_done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Next-state and datapath update for the batch sequencer.
    // NOTE: every _d signal gets its hold value first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        num_d         = num_q;
        gap_d         = gap_q;
        gap_cnt_d     = gap_cnt_q;
        timer_d       = timer_q;
        jobs_done_d   = jobs_done_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    jobs_done_d   = '0;
                    timeout_err_d = 1'b0;
                    if (num_jobs != '0) begin
                        num_d   = num_jobs;
                        gap_d   = gap;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                // A done on the last allowed cycle still counts: it is
                // checked before the timer.
                if (worker_done) begin
                    jobs_done_d = jobs_inc;
                    if (jobs_inc == num_q) begin
                        state_d = S_FINISH;
                    end else if (gap_q == '0) begin
                        state_d = S_ISSUE;
                    end else begin
                        gap_cnt_d = gap_q;
                        state_d   = S_GAP;
                    end
                end else if (timer_q == TMR_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_GAP: begin
                gap_cnt_d = gap_cnt_q - GAP_W'(1);
                if (gap_cnt_q == GAP_W'(1)) begin
                    state_d = S_ISSUE;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // All outputs decode registered state only.
    assign worker_start = (state_q == S_ISSUE);
    assign busy         = (state_q != S_IDLE);
    assign complete     = (state_q == S_FINISH);
    assign timeout_err  = timeout_err_q;
    assign jobs_done    = jobs_done_q;

endmodule

// File: tb/tb_fsm_job_sequencer.sv
// Directed bench for fsm_job_sequencer. Cycle c is the clock period that
// ends with rising edge c; inputs for cycle c are applied just after edge
// c-1 and outputs are sampled on the falling edge inside cycle c. Per-cycle
// observations are packed into bit vectors (bit c = cycle c) and compared
// against hand-computed patterns.
module tb_fsm_job_sequencer;

    localparam int JOB_W   = 8;
    localparam int GAP_W   = 8;
    localparam int TIMEOUT = 8;

    logic             clk;
    logic             reset;
    logic             go;
    logic [JOB_W-1:0] num_jobs;
    logic [GAP_W-1:0] gap;
    logic             worker_start;
    logic             worker_done;
    logic             busy;
    logic             complete;
    logic             timeout_err;
    logic [JOB_W-1:0] jobs_done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    fsm_job_sequencer #(
        .JOB_W   (JOB_W),
        .GAP_W   (GAP_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .go           (go),
        .num_jobs     (num_jobs),
        .gap          (gap),
        .worker_start (worker_start),
        .worker_done  (worker_done),
        .busy         (busy),
        .complete     (complete),
        .timeout_err  (timeout_err),
        .jobs_done    (jobs_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive n cycles from go/done bit patterns and record outputs per cycle.
    // Starts and ends #1 after a rising edge.
    task automatic run_seq(input int n, input logic [31:0] go_v, input logic [31:0] done_v,
                           output logic [31:0] st_v, output logic [31:0] bz_v,
                           output logic [31:0] cp_v, output logic [31:0] te_v);
        st_v = '0; bz_v = '0; cp_v = '0; te_v = '0;
        for (int c = 0; c < n; c++) begin
            go          = go_v[c];
            worker_done = done_v[c];
            @(negedge clk);
            st_v[c] = worker_start;
            bz_v[c] = busy;
            cp_v[c] = complete;
            te_v[c] = timeout_err;
            @(posedge clk);
            #1;
        end
        go          = 1'b0;
        worker_done = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] obs;
        go = 1'b0; worker_done = 1'b0; num_jobs = '0; gap = '0;
        reset = 1'b0;
        #2 reset = 1'b1;
        #1;
        obs = {worker_start, busy, complete, timeout_err, jobs_done};
        total_cnt++;
        if (obs !== 12'h000) $display("FAIL reset_outputs: got %h expected %h", obs, 12'h000);
        else pass_cnt++;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_three_jobs();
        logic [31:0] st, bz, cp, te;
        num_jobs = 8'd3; gap = 8'd0;
        run_seq(16, 32'h1, 32'h1110, st, bz, cp, te);
        total_cnt++;
        if (st !== 32'h0222) $display("FAIL three_starts: got %h expected %h", st, 32'h0222);
        else pass_cnt++;
        total_cnt++;
        if (cp !== 32'h2000) $display("FAIL three_complete: got %h expected %h", cp, 32'h2000);
        else pass_cnt++;
        total_cnt++;
        if (bz !== 32'h3FFE) $display("FAIL three_busy: got %h expected %h", bz, 32'h3FFE);
        else pass_cnt++;
        total_cnt++;
        if (jobs_done !== 8'd3) $display("FAIL three_jobs_done: got %0d expected %0d", jobs_done, 3);
        else pass_cnt++;
    endtask

    task automatic test_gap();
        logic [31:0] st, bz, cp, te;
        num_jobs = 8'd2; gap = 8'd2;
        run_seq(14, 32'h1, 32'h0410, st, bz, cp, te);
        total_cnt++;
        if (st !== 32'h0082) $display("FAIL gap_starts: got %h expected %h", st, 32'h0082);
        else pass_cnt++;
        total_cnt++;
        if (cp !== 32'h0800) $display("FAIL gap_complete: got %h expected %h", cp, 32'h0800);
        else pass_cnt++;
        total_cnt++;
        if (bz !== 32'h0FFE) $display("FAIL gap_busy: got %h expected %h", bz, 32'h0FFE);
        else pass_cnt++;
        total_cnt++;
        if (jobs_done !== 8'd2) $display("FAIL gap_jobs_done: got %0d expected %0d", jobs_done, 2);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        logic [31:0] st, bz, cp, te;
        num_jobs = 8'd5; gap = 8'd0;
        run_seq(12, 32'h1, 32'h0, st, bz, cp, te);
        total_cnt++;
        if (st !== 32'h0002) $display("FAIL timeout_starts: got %h expected %h", st, 32'h0002);
        else pass_cnt++;
        total_cnt++;
        if (te !== 32'h0C00) $display("FAIL timeout_err_flag: got %h expected %h", te, 32'h0C00);
        else pass_cnt++;
        total_cnt++;
        if (bz !== 32'h03FE) $display("FAIL timeout_busy: got %h expected %h", bz, 32'h03FE);
        else pass_cnt++;
        total_cnt++;
        if (cp !== 32'h0) $display("FAIL timeout_no_complete: got %h expected %h", cp, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (jobs_done !== 8'd0) $display("FAIL timeout_jobs_done: got %0d expected %0d", jobs_done, 0);
        else pass_cnt++;
        // New one-job batch; the worker answers one cycle after start.
        num_jobs = 8'd1;
        run_seq(6, 32'h1, 32'h4, st, bz, cp, te);
        total_cnt++;
        if (te !== 32'h0001) $display("FAIL timeout_cleared_by_go: got %h expected %h", te, 32'h0001);
        else pass_cnt++;
        total_cnt++;
        if (cp !== 32'h0008) $display("FAIL after_timeout_complete: got %h expected %h", cp, 32'h0008);
        else pass_cnt++;
    endtask

    task automatic test_zero_jobs();
        logic [31:0] st, bz, cp, te;
        num_jobs = 8'd0; gap = 8'd0;
        run_seq(4, 32'h1, 32'h0, st, bz, cp, te);
        total_cnt++;
        if (st !== 32'h0) $display("FAIL zero_no_start: got %h expected %h", st, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (cp !== 32'h2) $display("FAIL zero_complete: got %h expected %h", cp, 32'h2);
        else pass_cnt++;
        total_cnt++;
        if (jobs_done !== 8'd0) $display("FAIL zero_jobs_done: got %0d expected %0d", jobs_done, 0);
        else pass_cnt++;
    endtask

    task automatic test_spurious();
        logic [31:0] st, bz, cp, te;
        // go again in WAIT_DONE (3); done in GAP (5,6), ISSUE (7), FINISH (11), IDLE (12).
        num_jobs = 8'd2; gap = 8'd2;
        run_seq(14, 32'h9, 32'h1CF0, st, bz, cp, te);
        total_cnt++;
        if (st !== 32'h0082) $display("FAIL spurious_starts: got %h expected %h", st, 32'h0082);
        else pass_cnt++;
        total_cnt++;
        if (cp !== 32'h0800) $display("FAIL spurious_complete: got %h expected %h", cp, 32'h0800);
        else pass_cnt++;
        total_cnt++;
        if (jobs_done !== 8'd2) $display("FAIL spurious_jobs_done: got %0d expected %0d", jobs_done, 2);
        else pass_cnt++;
    endtask

    task automatic test_tie_break();
        logic [31:0] st, bz, cp, te;
        // Start at 1, WAIT_DONE cycles 2..9; done on cycle 9, the last allowed.
        num_jobs = 8'd1; gap = 8'd0;
        run_seq(13, 32'h1, 32'h0200, st, bz, cp, te);
        total_cnt++;
        if (te !== 32'h0) $display("FAIL tie_no_error: got %h expected %h", te, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (cp !== 32'h0400) $display("FAIL tie_complete: got %h expected %h", cp, 32'h0400);
        else pass_cnt++;
        total_cnt++;
        if (bz !== 32'h07FE) $display("FAIL tie_busy: got %h expected %h", bz, 32'h07FE);
        else pass_cnt++;
        total_cnt++;
        if (jobs_done !== 8'd1) $display("FAIL tie_jobs_done: got %0d expected %0d", jobs_done, 1);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] st, bz, cp, te;
        // Second go lands in the first IDLE cycle after FINISH.
        num_jobs = 8'd1; gap = 8'd0;
        run_seq(10, 32'h11, 32'h44, st, bz, cp, te);
        total_cnt++;
        if (st !== 32'h22) $display("FAIL b2b_starts: got %h expected %h", st, 32'h22);
        else pass_cnt++;
        total_cnt++;
        if (cp !== 32'h88) $display("FAIL b2b_complete: got %h expected %h", cp, 32'h88);
        else pass_cnt++;
        total_cnt++;
        if (bz !== 32'hEE) $display("FAIL b2b_busy: got %h expected %h", bz, 32'hEE);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_batch();
        logic [31:0] st, bz, cp, te;
        logic [11:0] obs;
        // First job done at 4, second start at 5; cycle 6 is WAIT_DONE.
        num_jobs = 8'd3; gap = 8'd0;
        run_seq(6, 32'h1, 32'h10, st, bz, cp, te);
        obs = {worker_start, busy, complete, timeout_err, jobs_done};
        total_cnt++;
        if (obs !== 12'h401) $display("FAIL midreset_pre: got %h expected %h", obs, 12'h401);
        else pass_cnt++;
        #1 reset = 1'b1;
        #1;
        obs = {worker_start, busy, complete, timeout_err, jobs_done};
        total_cnt++;
        if (obs !== 12'h000) $display("FAIL midreset_async: got %h expected %h", obs, 12'h000);
        else pass_cnt++;
        @(posedge clk);
        #1 reset = 1'b0;
        num_jobs = 8'd1;
        run_seq(6, 32'h1, 32'h4, st, bz, cp, te);
        total_cnt++;
        if (st !== 32'h2) $display("FAIL midreset_restart_start: got %h expected %h", st, 32'h2);
        else pass_cnt++;
        total_cnt++;
        if (cp !== 32'h8) $display("FAIL midreset_restart_complete: got %h expected %h", cp, 32'h8);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_three_jobs();
        test_gap();
        test_timeout();
        test_zero_jobs();
        test_spurious();
        test_tie_break();
        test_back_to_back();
        test_reset_mid_batch();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
